multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multicycle sequencer for the simple_cpu core. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB, and drives the per-cycle datapath strobes: PC/IR/old-PC writes, ALU operand selects, ALU op, immediate format, result select and register write. It also runs the ready/request handshake with a single shared instruction/data memory port. It sits beside the datapath and takes opcode/funct3 from the instruction register and the branch decision from the branch comparator.

## Interface
- No parameters. State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- opcode  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- branch_taken  in  1  comparator result for the current branch
- mem_ready  in  1  memory completes the current request at this edge
- mem_req  out  1  memory request
- mem_we  out  1  write request, valid with mem_req
- mem_addr_sel  out  1  0=PC, 1=ALUOut
- ir_write, old_pc_write, pc_write  out  1 each  register enables
- pc_src  out  2  00=PC+4, 01=ALUOut, 10=ALU result
- alu_src_a  out  2  00=rs1, 01=old PC, 10=zero
- alu_src_b  out  2  00=rs2, 01=immediate
- alu_op  out  2  00=add, 01=branch compare, 10=funct decode
- imm_src  out  3  `Imm_I/S/B/J/U` codes from defines.vh
- result_src  out  2  00=ALUOut, 01=mem data reg, 10=old PC+4
- reg_write  out  1  register-file write enable
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction
- illegal  out  1  trap flag (see Configuration)
- state  out  3  current state, for debug

## Operation
- **Output type.** Outputs are combinational from state, opcode, funct3, branch_taken and mem_ready. Every output not named for a state is 0 in that state.
- **FETCH.** mem_req=1, mem_addr_sel=0. Hold until mem_ready=1. In that cycle: ir_write=1, old_pc_write=1, pc_write=1, pc_src=00. Next state DECODE.
- **DECODE.** Precompute the branch target: alu_src_a=01, alu_src_b=01, alu_op=00, imm_src=`Imm_B`.
  - Legal opcode → EXEC.
  - Illegal opcode → see Configuration.
  - Illegal means: opcode outside {RTYPE, ITYPE, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC}, or JALR with funct3≠000.
- **EXEC**, by opcode:
  - RTYPE: a=00, b=00, op=10 → WB.
  - ITYPE: a=00, b=01, op=10, `Imm_I` → WB.
  - LOAD: a=00, b=01, op=00, `Imm_I` → MEM.
  - STORE: a=00, b=01, op=00, `Imm_S` → MEM.
  - BRANCH: a=00, b=00, op=01; pc_write=branch_taken, pc_src=01; instr_done=1 → FETCH.
  - JAL: a=01, b=01, op=00, `Imm_J`; pc_write=1, pc_src=10 → WB.
  - JALR: a=00, b=01, op=00, `Imm_I`; pc_write=1, pc_src=10 → WB.
  - LUI: a=10, b=01, op=00, `Imm_U` → WB.
  - AUIPC: a=01, b=01, op=00, `Imm_U` → WB.
- **MEM.** mem_req=1, mem_addr_sel=1, mem_we=(STORE). Hold until mem_ready=1.
  - LOAD → WB.
  - STORE: instr_done=1 in the ready cycle → FETCH.
- **WB.** reg_write=1, instr_done=1 → FETCH.
  - result_src=01 for LOAD, 10 for JAL/JALR, 00 otherwise.
- **Memory handshake.**
  - mem_req, mem_we and mem_addr_sel stay stable from assertion until the edge where mem_ready=1.
  - mem_ready is ignored while mem_req=0.
  - mem_req drops in the cycle after completion. There are no back-to-back requests.

## Timing
- **Reset.**
  - While rst=1: state=FETCH and every output is forced to 0, including mem_req; state reads 0.
  - Reset asserted mid-instruction aborts it asynchronously. No partial strobes are issued.
  - The first fetch request appears in the first cycle after rst deasserts.
- **Latency with mem_ready tied high:**
  - BRANCH: 3 cycles.
  - RTYPE, ITYPE, LUI, AUIPC, JAL, JALR, STORE: 4 cycles.
  - LOAD: 5 cycles.
  - Each wait-cycle in FETCH or MEM adds exactly one cycle.
- **Input stability.** opcode and funct3 are stable from DECODE through the end of the instruction, because the IR is written only in FETCH.

## Configuration
- **`ILLEGAL_TRAP_EN` defined:**
  - An illegal instruction in DECODE goes to HALT.
  - In HALT: illegal=1, all strobes 0, no mem_req. HALT is left only by reset.
- **`ILLEGAL_TRAP_EN` undefined:**
  - An illegal instruction is a NOP: DECODE asserts instr_done=1 → FETCH.
  - PC has already advanced by 4. illegal is tied to 0 and HALT is unreachable.

## Test plan
- ADD (opcode 0110011), mem_ready=1 → states 0,1,2,4,0; reg_write=1 only in WB; instr_done pulses once; 4 cycles.
- LW (0000011) with mem_ready low for 2 cycles in MEM → mem_req held 3 cycles with mem_addr_sel=1, mem_we=0; result_src=01 in WB; 7 cycles total.
- BEQ (1100011): with branch_taken=1 → pc_write=1, pc_src=01 in EXEC; with branch_taken=0 → pc_write=0 in EXEC; 3 cycles each, no WB.
- JALR with funct3=000 → EXEC pc_src=10, WB result_src=10. With funct3=001 and `ILLEGAL_TRAP_EN` defined → state 5, illegal=1, no further mem_req.
- SW (0100011), rst pulsed while in MEM → mem_req drops immediately; after release, state=0 and the first cycle shows mem_req=1, mem_addr_sel=0.
- Opcode 1111111 with `ILLEGAL_TRAP_EN` undefined → instr_done pulses in DECODE, return to FETCH, illegal stays 0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle sequencer for simple_cpu: FETCH/DECODE/EXEC/MEM/WB control with a shared memory handshake.
// Optional macro ILLEGAL_TRAP_EN: illegal instructions halt the core instead of executing as NOPs.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       ir_write,
    output logic       old_pc_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [2:0] imm_src,
    output logic [1:0] result_src,
    output logic       reg_write,
    output logic       instr_done,
    output logic       illegal,
    output logic [2:0] state
);

    localparam logic [2:0] FETCH  = 3'd0;
    localparam logic [2:0] DECODE = 3'd1;
    localparam logic [2:0] EXEC   = 3'd2;
    localparam logic [2:0] MEM    = 3'd3;
    localparam logic [2:0] WB     = 3'd4;
    localparam logic [2:0] HALT   = 3'd5;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Immediate-format codes, matching the Imm_* values of the datapath's defines.vh.
    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    logic [2:0] state_reg;
    logic [2:0] state_next;
    logic       legal;

    always_comb begin
        case (opcode)
            OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_LUI, OP_AUIPC: legal = 1'b1;
            OP_JALR:                  legal = (funct3 == 3'b000);
            default:                  legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    assign state = state_reg;

    // Strobes are gated by rst so nothing partial escapes while reset is held.
    always_comb begin
        state_next   = state_reg;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_write     = 1'b0;
        old_pc_write = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 2'b00;
        alu_src_a    = 2'b00;
        alu_src_b    = 2'b00;
        alu_op       = 2'b00;
        imm_src      = 3'b000;
        result_src   = 2'b00;
        reg_write    = 1'b0;
        instr_done   = 1'b0;
        illegal      = 1'b0;
        if (!rst) begin
            case (state_reg)
                FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write     = 1'b1;
                        old_pc_write = 1'b1;
                        pc_write     = 1'b1;
                        state_next   = DECODE;
                    end
                end
                DECODE: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b01;
                    imm_src   = IMM_B;
                    if (legal) begin
                        state_next = EXEC;
                    end else begin
`ifdef ILLEGAL_TRAP_EN
                        state_next = HALT;
`else
                        instr_done = 1'b1;
                        state_next = FETCH;
`endif
                    end
                end
                EXEC: begin
                    state_next = WB;
                    case (opcode)
                        OP_RTYPE: alu_op = 2'b10;
                        OP_ITYPE: begin
                            alu_src_b = 2'b01;
                            alu_op    = 2'b10;
                            imm_src   = IMM_I;
                        end
                        OP_LOAD: begin
                            alu_src_b  = 2'b01;
                            imm_src    = IMM_I;
                            state_next = MEM;
                        end
                        OP_STORE: begin
                            alu_src_b  = 2'b01;
                            imm_src    = IMM_S;
                            state_next = MEM;
                        end
                        OP_BRANCH: begin
                            alu_op     = 2'b01;
                            pc_write   = branch_taken;
                            pc_src     = 2'b01;
                            instr_done = 1'b1;
                            state_next = FETCH;
                        end
                        OP_JAL: begin
                            alu_src_a = 2'b01;
                            alu_src_b = 2'b01;
                            imm_src   = IMM_J;
                            pc_write  = 1'b1;
                            pc_src    = 2'b10;
                        end
                        OP_JALR: begin
                            alu_src_b = 2'b01;
                            imm_src   = IMM_I;
                            pc_write  = 1'b1;
                            pc_src    = 2'b10;
                        end
                        OP_LUI: begin
                            alu_src_a = 2'b10;
                            alu_src_b = 2'b01;
                            imm_src   = IMM_U;
                        end
                        OP_AUIPC: begin
                            alu_src_a = 2'b01;
                            alu_src_b = 2'b01;
                            imm_src   = IMM_U;
                        end
                        default: state_next = FETCH;
                    endcase
                end
                MEM: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    mem_we       = (opcode == OP_STORE);
                    if (mem_ready) begin
                        if (opcode == OP_STORE) begin
                            instr_done = 1'b1;
                            state_next = FETCH;
                        end else begin
                            state_next = WB;
                        end
                    end
                end
                WB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                    state_next = FETCH;
                    if (opcode == OP_LOAD) begin
                        result_src = 2'b01;
                    end else if (opcode == OP_JAL || opcode == OP_JALR) begin
                        result_src = 2'b10;
                    end
                end
                HALT: begin
`ifdef ILLEGAL_TRAP_EN
                    illegal    = 1'b1;
                    state_next = HALT;
`else
                    state_next = FETCH;
`endif
                end
                default: state_next = FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed plan items plus randomized instruction streams.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       branch_taken;
    logic       mem_ready;
    logic       mem_req, mem_we, mem_addr_sel, ir_write, old_pc_write, pc_write;
    logic [1:0] pc_src, alu_src_a, alu_src_b, alu_op, result_src;
    logic [2:0] imm_src;
    logic       reg_write, instr_done, illegal;
    logic [2:0] state;

    multicycle_ctrl dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3),
        .branch_taken(branch_taken), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
        .ir_write(ir_write), .old_pc_write(old_pc_write), .pc_write(pc_write),
        .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .imm_src(imm_src), .result_src(result_src),
        .reg_write(reg_write), .instr_done(instr_done), .illegal(illegal),
        .state(state)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] RTYPE = 7'b0110011, ITYPE = 7'b0010011, LOAD = 7'b0000011,
                           STORE = 7'b0100011, BRANCH = 7'b1100011, JAL = 7'b1101111,
                           JALR = 7'b1100111, LUI = 7'b0110111, AUIPC = 7'b0010111;
    localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3, IMM_J = 3'd4;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Expected values for the current cycle
    logic       e_req, e_we, e_addr, e_ir, e_old, e_pcw, e_rw, e_done, e_ill;
    logic [1:0] e_pcs, e_a, e_b, e_op, e_res;
    logic [2:0] e_imm, e_state;

    task automatic clr(input logic [2:0] st);
        e_state = st;
        {e_req, e_we, e_addr, e_ir, e_old, e_pcw, e_rw, e_done, e_ill} = '0;
        {e_pcs, e_a, e_b, e_op, e_res} = '0;
        e_imm = '0;
    endtask

    task automatic check_now(input string tag);
        logic [21:0] obs, expv;
        obs  = {mem_req, mem_we, mem_addr_sel, ir_write, old_pc_write, pc_write, pc_src,
                alu_src_a, alu_src_b, alu_op, imm_src, result_src, reg_write, instr_done, illegal};
        expv = {e_req, e_we, e_addr, e_ir, e_old, e_pcw, e_pcs,
                e_a, e_b, e_op, e_imm, e_res, e_rw, e_done, e_ill};
        vectors++;
        assert (state === e_state) else begin
            miscompares++;
            $error("FAIL %s state: observed %0d expected %0d", tag, state, e_state);
        end
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s outputs: observed %06h expected %06h (state %0d)", tag, obs, expv, state);
        end
    endtask

    // One clock cycle: drive mem_ready, check combinational outputs, advance.
    task automatic step(input logic rdy, input string tag);
        mem_ready = rdy;
        #1;
        check_now(tag);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        clr(3'd0);
        check_now(tag);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Reference: walk one instruction through the phase rules and check every cycle.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic bt,
                             input int fw, input int mw, input bit abort_in_mem);
        int  start;
        int  exp_lat;
        bit  legal, is_mem;
        start = cyc;
        opcode = op;
        funct3 = f3;
        branch_taken = bt;
        legal = (op inside {RTYPE, ITYPE, LOAD, STORE, BRANCH, JAL, LUI, AUIPC})
                || (op == JALR && f3 == 3'b000);
        is_mem = (op == LOAD || op == STORE);

        for (int i = 0; i < fw; i++) begin
            clr(3'd0); e_req = 1;
            step(1'b0, "fetch_wait");
        end
        clr(3'd0); e_req = 1; e_ir = 1; e_old = 1; e_pcw = 1;
        step(1'b1, "fetch");

        clr(3'd1); e_a = 2'b01; e_b = 2'b01; e_imm = IMM_B;
`ifndef ILLEGAL_TRAP_EN
        if (!legal) e_done = 1;
`endif
        step(1'($urandom_range(0, 1)), "decode");
        if (!legal) begin
`ifdef ILLEGAL_TRAP_EN
            for (int i = 0; i < 4; i++) begin
                clr(3'd5); e_ill = 1;
                step(1'($urandom_range(0, 1)), "halt");
            end
            do_reset("halt_rst");
`else
            vectors++;
            assert (cyc - start === 2 + fw) else begin
                miscompares++;
                $error("FAIL nop_latency: observed %0d expected %0d", cyc - start, 2 + fw);
            end
`endif
            return;
        end

        clr(3'd2);
        case (op)
            RTYPE:  e_op = 2'b10;
            ITYPE:  begin e_b = 2'b01; e_op = 2'b10; e_imm = IMM_I; end
            LOAD:   begin e_b = 2'b01; e_imm = IMM_I; end
            STORE:  begin e_b = 2'b01; e_imm = IMM_S; end
            BRANCH: begin e_op = 2'b01; e_pcw = bt; e_pcs = 2'b01; e_done = 1; end
            JAL:    begin e_a = 2'b01; e_b = 2'b01; e_imm = IMM_J; e_pcw = 1; e_pcs = 2'b10; end
            JALR:   begin e_b = 2'b01; e_imm = IMM_I; e_pcw = 1; e_pcs = 2'b10; end
            LUI:    begin e_a = 2'b10; e_b = 2'b01; e_imm = IMM_U; end
            default: begin e_a = 2'b01; e_b = 2'b01; e_imm = IMM_U; end
        endcase
        step(1'($urandom_range(0, 1)), "exec");

        if (is_mem) begin
            if (abort_in_mem) begin
                clr(3'd3); e_req = 1; e_addr = 1; e_we = (op == STORE);
                mem_ready = 1'b0;
                #1;
                check_now("mem_pre_rst");
                #1;
                rst = 1'b1;
                #1;
                clr(3'd0);
                check_now("mem_rst");
                @(posedge clk);
                #1;
                rst = 1'b0;
                return;
            end
            for (int i = 0; i < mw; i++) begin
                clr(3'd3); e_req = 1; e_addr = 1; e_we = (op == STORE);
                step(1'b0, "mem_wait");
            end
            clr(3'd3); e_req = 1; e_addr = 1; e_we = (op == STORE); e_done = (op == STORE);
            step(1'b1, "mem");
        end

        if (op != BRANCH && op != STORE) begin
            clr(3'd4); e_rw = 1; e_done = 1;
            e_res = (op == LOAD) ? 2'b01 : ((op == JAL || op == JALR) ? 2'b10 : 2'b00);
            step(1'($urandom_range(0, 1)), "wb");
        end

        exp_lat = (op == BRANCH) ? 3 : ((op == LOAD) ? 5 : 4);
        exp_lat += fw + (is_mem ? mw : 0);
        vectors++;
        assert (cyc - start === exp_lat) else begin
            miscompares++;
            $error("FAIL latency op=%b: observed %0d expected %0d", op, cyc - start, exp_lat);
        end
    endtask

    initial begin
        logic [6:0] ops [9];
        int idx;
        logic [6:0] op;
        logic [2:0] f3;
        ops = '{RTYPE, ITYPE, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC};

        rst = 1'b1;
        opcode = LOAD;
        funct3 = 3'b000;
        branch_taken = 1'b1;
        mem_ready = 1'b1;
        #2;
        clr(3'd0);
        check_now("reset");
        repeat (2) @(posedge clk);
        #2;
        check_now("reset_held");
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_instr(RTYPE, 3'b000, 1'b0, 0, 0, 0);
        run_instr(LOAD, 3'b010, 1'b0, 0, 2, 0);
        run_instr(BRANCH, 3'b000, 1'b1, 0, 0, 0);
        run_instr(BRANCH, 3'b000, 1'b0, 0, 0, 0);
        run_instr(JALR, 3'b000, 1'b0, 1, 0, 0);
        run_instr(STORE, 3'b010, 1'b0, 0, 0, 1);
        run_instr(ITYPE, 3'b000, 1'b0, 0, 0, 0);
`ifndef ILLEGAL_TRAP_EN
        run_instr(7'b1111111, 3'b000, 1'b0, 0, 0, 0);
        run_instr(JALR, 3'b001, 1'b0, 0, 0, 0);
`endif

        for (int n = 0; n < 80; n++) begin
            idx = $urandom_range(0, 10);
            f3 = 3'($urandom_range(0, 7));
            if (idx < 9) begin
                op = ops[idx];
                if (op == JALR) f3 = 3'b000;
            end else if (idx == 9) begin
                op = ($urandom_range(0, 1) == 0) ? 7'b1111111 : 7'b0000000;
            end else begin
                op = JALR;
                f3 = 3'($urandom_range(1, 7));
            end
`ifdef ILLEGAL_TRAP_EN
            if (idx >= 9) begin
                op = ops[n % 9];
                if (op == JALR) f3 = 3'b000;
            end
`endif
            run_instr(op, f3, 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                      $urandom_range(0, 2), 0);
        end

`ifdef ILLEGAL_TRAP_EN
        run_instr(JALR, 3'b001, 1'b0, 0, 0, 0);
        run_instr(ADD_OP(), 3'b000, 1'b0, 0, 0, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

`ifdef ILLEGAL_TRAP_EN
    function automatic logic [6:0] ADD_OP();
        return RTYPE;
    endfunction
`endif

endmodule
